// File: rtl/crc32_checker.sv
// Streaming CRC-32 checker: accepts 32-bit payload words, folds them in one byte per
// cycle (byte [7:0] first), then compares the finished CRC against a received CRC word.
module crc32_checker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_in,
    input  logic             start,
    input  logic             data_valid,
    input  logic             data_last,
    input  logic [31:0]      crc_in,
    input  logic             crc_valid,
    output logic             ready,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [31:0]      crc_calc,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [31:0]      Poly    = 32'hEDB88320;
    localparam logic [31:0]      CrcInit = 32'hFFFFFFFF;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StShift   = 3'd1,
        StNext    = 3'd2,
        StWaitCrc = 3'd3,
        StDone    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      crc_calc_q, crc_calc_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_err_q, crc_err_d;

    logic [7:0]       cur_byte;
    logic             take_start;

    // Reflected CRC-32 update for one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ Poly) : (r >> 1);
        end
        return r;
    endfunction

    assign cur_byte = word_q[{byte_cnt_q, 3'b000} +: 8];

    // Ready is a decode of the registered state, so it is glitch-free and low in SHIFT/DONE.
    always_comb begin
        ready = (state_q == StIdle) || (state_q == StNext) || (state_q == StWaitCrc);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        word_d       = word_q;
        last_d       = last_q;
        byte_cnt_d   = byte_cnt_q;
        crc_calc_d   = crc_calc_q;
        word_count_d = word_count_q;
        done_d       = 1'b0;
        crc_ok_d     = crc_ok_q;
        crc_err_d    = crc_err_q;
        take_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                take_start = data_valid && start;
            end
            StShift: begin
                acc_d      = crc_byte(acc_q, cur_byte);
                crc_calc_d = ~acc_d;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    state_d = last_q ? StWaitCrc : StNext;
                end
            end
            StNext: begin
                if (data_valid && start) begin
                    // Restart discards the partial frame.
                    take_start = 1'b1;
                end else if (data_valid) begin
                    word_d       = data_in;
                    last_d       = data_last;
                    byte_cnt_d   = 2'd0;
                    word_count_d = (word_count_q == CntMax) ? CntMax : word_count_q + CntOne;
                    state_d      = StShift;
                end
            end
            StWaitCrc: begin
                if (crc_valid) begin
                    crc_ok_d  = (crc_calc_q == crc_in);
                    crc_err_d = (crc_calc_q != crc_in);
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take_start) begin
            word_d       = data_in;
            last_d       = data_last;
            acc_d        = CrcInit;
            byte_cnt_d   = 2'd0;
            word_count_d = CntOne;
            crc_ok_d     = 1'b0;
            crc_err_d    = 1'b0;
            state_d      = StShift;
        end
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= CrcInit;
            word_q       <= 32'h0;
            last_q       <= 1'b0;
            byte_cnt_q   <= 2'd0;
            crc_calc_q   <= 32'h0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            last_q       <= last_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_calc_q   <= crc_calc_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            crc_ok_q     <= crc_ok_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign done       = done_q;
    assign crc_ok     = crc_ok_q;
    assign crc_err    = crc_err_q;
    assign crc_calc   = crc_calc_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_crc32_checker.sv
// Scoreboarded bench for crc32_checker: directed corner frames plus random frames,
// checked against a table-driven CRC-32 model.
module tb_crc32_checker;

    localparam int unsigned CNT_W = 2;  // small so counter saturation is reachable

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      data_in = '0;
    logic             start = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_last = 1'b0;
    logic [31:0]      crc_in = '0;
    logic             crc_valid = 1'b0;
    logic             ready, done, crc_ok, crc_err;
    logic [31:0]      crc_calc;
    logic [CNT_W-1:0] word_count;

    crc32_checker #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .start     (start),
        .data_valid(data_valid),
        .data_last (data_last),
        .crc_in    (crc_in),
        .crc_valid (crc_valid),
        .ready     (ready),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .crc_calc  (crc_calc),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      crc;
        logic             ok;
        logic             err;
        logic [CNT_W-1:0] wc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] crc_table[256];
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_table();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = n;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_table[n] = c;
        end
    endfunction

    // Reference CRC-32 of a whole frame of words, bytes little-end first.
    function automatic logic [31:0] ref_crc(input logic [31:0] words[$]);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        foreach (words[i]) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'((words[i] >> (8 * j)) & 32'hFF);
                c = (c >> 8) ^ crc_table[(c[7:0] ^ b)];
            end
        end
        return ~c;
    endfunction

    function automatic logic [CNT_W-1:0] exp_wc(input int n);
        int m;
        m = (1 << CNT_W) - 1;
        return CNT_W'((n > m) ? m : n);
    endfunction

    // Offer a word from the next falling edge, holding it until an edge where ready was high.
    task automatic send_word(input logic [31:0] d, input logic s, input logic l);
        logic r;
        bit   ok;
        ok = 0;
        @(negedge clk);
        data_in = d; start = s; data_last = l; data_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = ready;
            @(posedge clk);
            if (r) begin ok = 1; break; end
            @(negedge clk);
        end
        #1;
        data_valid = 1'b0; start = 1'b0; data_last = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL word_accept_timeout: got no ready, expected ready within 50 cycles");
        end
    endtask

    task automatic send_crc(input logic [31:0] c);
        logic r;
        bit   ok;
        ok = 0;
        @(negedge clk);
        crc_in = c; crc_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = ready;
            @(posedge clk);
            if (r) begin ok = 1; break; end
            @(negedge clk);
        end
        #1;
        crc_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL crc_accept_timeout: got no ready, expected ready within 50 cycles");
        end
    endtask

    task automatic push_exp(input logic [31:0] c, input logic ok, input int n);
        exp_t e;
        e.crc = c; e.ok = ok; e.err = !ok; e.wc = exp_wc(n);
        sb.push_back(e);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            if (prev_done) chk("done_one_cycle", 32'(done), 32'h0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("crc_calc", crc_calc, e.crc);
                chk("crc_ok", 32'(crc_ok), 32'(e.ok));
                chk("crc_err", 32'(crc_err), 32'(e.err));
                chk("word_count", 32'(word_count), 32'(e.wc));
            end
        end
        prev_done = done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      words[$];
        logic [31:0]      c;
        logic             held_ok;
        logic [CNT_W-1:0] wc_before;
        build_table();

        // Reset values.
        #12;
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ok_err", {30'h0, crc_ok, crc_err}, 32'h0);
        chk("rst_crc_calc", crc_calc, 32'h0);
        chk("rst_word_count", 32'(word_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // One-word frame with ready throughput timing.
        push_exp(32'h2144DF1C, 1'b1, 1);
        send_word(32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ready_low_in_shift", 32'(ready), 32'h0);
        end
        @(negedge clk);
        chk("ready_back_after_4", 32'(ready), 32'h1);
        send_crc(32'h2144DF1C);

        // Inputs ignored in IDLE; crc_ok held.
        repeat (2) @(negedge clk);
        held_ok = crc_ok;
        wc_before = word_count;
        data_valid = 1'b1; crc_valid = 1'b1; data_in = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("idle_ignore_ready", 32'(ready), 32'h1);
        chk("idle_ignore_wc", 32'(word_count), 32'(wc_before));
        chk("idle_hold_ok", 32'(crc_ok), 32'h1);
        data_valid = 1'b0; crc_valid = 1'b0;

        // Mismatch frame; status cleared at frame start.
        push_exp(32'hFFFFFFFF, 1'b0, 1);
        send_word(32'hFFFFFFFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("status_clear_on_start", {30'h0, crc_ok, crc_err}, 32'h0);
        send_crc(32'h12345678);

        // Two-word frame, second word offered during SHIFT.
        push_exp(32'h6522DF69, 1'b1, 2);
        send_word(32'h0, 1'b1, 1'b0);
        send_word(32'h0, 1'b0, 1'b1);
        send_crc(32'h6522DF69);

        // Restart in NEXT.
        push_exp(32'h2144DF1C, 1'b1, 1);
        send_word(32'hA5A5A5A5, 1'b1, 1'b0);
        send_word(32'h0, 1'b1, 1'b1);
        send_crc(32'h2144DF1C);

        // Data/start ignored in WAIT_CRC.
        words = {32'h01234567};
        push_exp(ref_crc(words), 1'b1, 1);
        send_word(32'h01234567, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        wc_before = word_count;
        data_valid = 1'b1; start = 1'b1; data_in = 32'h0;
        repeat (2) @(negedge clk);
        chk("waitcrc_ignore_ready", 32'(ready), 32'h1);
        chk("waitcrc_ignore_wc", 32'(word_count), 32'(wc_before));
        data_valid = 1'b0; start = 1'b0;
        send_crc(ref_crc(words));

        // Reset during the second SHIFT cycle, then start on the first edge after release.
        send_word(32'h12345678, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'h1);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_crc_calc", crc_calc, 32'h0);
        chk("midrst_word_count", 32'(word_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        data_in = 32'h0; start = 1'b1; data_last = 1'b1; data_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_accept", 32'(ready), 32'h0);
        data_valid = 1'b0; start = 1'b0; data_last = 1'b0;
        push_exp(32'h2144DF1C, 1'b1, 1);
        send_crc(32'h2144DF1C);

        // Random frames, including word counter saturation.
        for (int f = 0; f < 30; f++) begin
            int n;
            bit good;
            n = $urandom_range(1, 6);
            good = ($urandom_range(0, 1) == 1);
            words.delete();
            for (int w = 0; w < n; w++) words.push_back($urandom);
            c = ref_crc(words);
            push_exp(c, good, n);
            for (int w = 0; w < n; w++) begin
                send_word(words[w], (w == 0), (w == n - 1));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            send_crc(good ? c : (c ^ (32'h1 << $urandom_range(0, 31))));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc32_checker.md
CRC32_CHECKER -- requirements
Module: crc32_checker

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the frame word counter.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port data_in, input, 32 bits: payload word, processed byte [7:0] first through byte [31:24] last.
REQ-005 The module SHALL have port start, input, 1 bit: qualifies the first word of a frame; only meaningful together with data_valid.
REQ-006 The module SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-007 The module SHALL have port data_last, input, 1 bit: the accepted word is the final payload word.
REQ-008 The module SHALL have port crc_in, input, 32 bits: received CRC word for the frame.
REQ-009 The module SHALL have port crc_valid, input, 1 bit: crc_in is valid.
REQ-010 The module SHALL have port ready, output, 1 bit: the module can accept a data word or CRC word this cycle.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse when the check completes.
REQ-012 The module SHALL have port crc_ok, output, 1 bit: last frame matched; held until the next frame start.
REQ-013 The module SHALL have port crc_err, output, 1 bit: last frame mismatched; held until the next frame start.
REQ-014 The module SHALL have port crc_calc, output, 32 bits: computed final CRC, already XORed with 0xFFFFFFFF.
REQ-015 The module SHALL have port word_count, output, CNT_W bits: number of payload words accepted in the current frame.

Function
REQ-016 The CRC SHALL be standard CRC-32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, reflected input and output, final XOR 0xFFFFFFFF.
REQ-017 The FSM SHALL have exactly the states IDLE, SHIFT, NEXT, WAIT_CRC and DONE.
REQ-018 In IDLE, ready SHALL be 1; data_valid && start SHALL accept the word, reset the accumulator to 0xFFFFFFFF, set word_count to 1, clear crc_ok and crc_err, and go to SHIFT.
REQ-019 In IDLE, data_valid without start SHALL be ignored, and crc_valid SHALL be ignored.
REQ-020 In SHIFT, the module SHALL process one byte per cycle for exactly 4 cycles with ready held at 0, then go to NEXT, or to WAIT_CRC if the word was accepted with data_last=1.
REQ-021 Word throughput SHALL be as follows: a word accepted at edge k leaves ready low for cycles k+1..k+4, and ready is 1 again after edge k+4.
REQ-022 In NEXT, ready SHALL be 1; data_valid SHALL accept the next word, increment word_count, and go to SHIFT.
REQ-023 In NEXT, start && data_valid SHALL restart the frame exactly as in REQ-018, and the previous partial frame SHALL be discarded.
REQ-024 In WAIT_CRC, ready SHALL be 1; data_valid and start SHALL be ignored.
REQ-025 In WAIT_CRC, crc_valid SHALL latch the comparison (crc_calc == crc_in) and go to DONE.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle with crc_ok/crc_err valid, ready SHALL be 0, and the next state SHALL be IDLE.
REQ-027 crc_ok and crc_err SHALL never both be 1; both SHALL be 0 from frame start until DONE.
REQ-028 crc_calc SHALL update after each processed byte and hold its value in IDLE.
REQ-029 word_count SHALL saturate at 2^CNT_W-1, not wrap.
REQ-030 data_last accepted on the start word SHALL make a valid one-word frame.

Reset
REQ-031 rst SHALL force, asynchronously: state IDLE, accumulator 0xFFFFFFFF, crc_calc 0x00000000, word_count 0, done 0, crc_ok 0, crc_err 0.
REQ-032 ready SHALL be 1 once rst deasserts, and the first start SHALL be accepted on the first rising edge after deassertion.
REQ-033 rst asserted mid-frame, in any state, SHALL abandon the frame with no done pulse.

Verification
REQ-034 One-word frame: start+valid+last with data 0x00000000, then crc_in 0x2144DF1C -> crc_calc=0x2144DF1C, done pulse 1 cycle, crc_ok=1, crc_err=0.
REQ-035 Mismatch frame: data 0xFFFFFFFF (last), then crc_in 0x12345678 -> crc_calc=0xFFFFFFFF, done pulse, crc_err=1, crc_ok=0.
REQ-036 Two-word frame: 0x00000000 then 0x00000000 (last); the second word is offered while ready=0 and accepted only in NEXT; word_count=2; matching CRC 0x2144DF1C is NOT expected (CRC of 8 zero bytes = 0x6522DF69) -> crc_ok=1 with crc_in=0x6522DF69.
REQ-037 Restart: first word accepted, then start+valid in NEXT with 0x00000000 (last), crc_in 0x2144DF1C -> word_count=1, crc_ok=1.
REQ-038 Ignored inputs: data_valid without start in IDLE, and data_valid in WAIT_CRC -> no state change, word_count unchanged.
REQ-039 Reset mid-SHIFT: assert rst during cycle 2 of SHIFT -> all outputs at reset values immediately, no done pulse, ready=1 after release.
